// File: rtl/move_sequencer.sv
// Central 2048 game controller: arbitrates direction buttons, sequences
// move/spawn/evaluate for each turn, and owns new-game setup and end states.
module move_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int INIT_SPAWNS    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic [63:0] board,
  input  logic [63:0] moved_board,
  input  logic        move_done,
  input  logic        spawn_done,
  input  logic        game_over,
  input  logic        game_complete,
  output logic        board_clr,
  output logic        move_start,
  output logic [1:0]  move_dir,
  output logic        spawn_req,
  output logic        busy,
  output logic        win,
  output logic        lose,
  output logic        err_timeout,
  output logic [15:0] move_count,
  output logic [2:0]  state_o
);

  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SCW = (INIT_SPAWNS > 1) ? $clog2(INIT_SPAWNS) : 1;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_MOVE  = 3'd2,
    S_SPAWN = 3'd3,
    S_EVAL  = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6
  } state_t;

  // New-game setup runs clear, then a request/wait loop per initial tile
  typedef enum logic [1:0] {
    P_CLR  = 2'd0,
    P_REQ  = 2'd1,
    P_WAIT = 2'd2
  } init_phase_t;

  state_t      state, state_n;
  init_phase_t phase, phase_n;
  logic [SCW-1:0] spawn_cnt, spawn_cnt_n;
  logic [TW-1:0]  timer, timer_n;
  logic [63:0]    snapshot, snapshot_n;
  logic [1:0]     dir_n;
  logic [15:0]    count_n;
  logic           err_n, clr_n, start_n, sreq_n;
  logic           any_btn, timer_hit;

  assign any_btn   = btn_up | btn_down | btn_left | btn_right;
  assign timer_hit = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign state_o   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT;
      phase       <= P_CLR;
      spawn_cnt   <= '0;
      timer       <= '0;
      snapshot    <= '0;
      move_dir    <= 2'b00;
      move_count  <= '0;
      err_timeout <= 1'b0;
      board_clr   <= 1'b0;
      move_start  <= 1'b0;
      spawn_req   <= 1'b0;
      busy        <= 1'b1;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      spawn_cnt   <= spawn_cnt_n;
      timer       <= timer_n;
      snapshot    <= snapshot_n;
      move_dir    <= dir_n;
      move_count  <= count_n;
      err_timeout <= err_n;
      board_clr   <= clr_n;
      move_start  <= start_n;
      spawn_req   <= sreq_n;
      busy        <= (state_n != S_IDLE);
      win         <= (state_n == S_WIN);
      lose        <= (state_n == S_LOSE);
    end
  end

  // The timer only advances while waiting for a done pulse; every other path leaves it at zero
  always_comb begin
    state_n     = state;
    phase_n     = phase;
    spawn_cnt_n = spawn_cnt;
    timer_n     = '0;
    snapshot_n  = snapshot;
    dir_n       = move_dir;
    count_n     = move_count;
    err_n       = err_timeout;
    clr_n       = 1'b0;
    start_n     = 1'b0;
    sreq_n      = 1'b0;

    case (state)
      S_INIT: begin
        case (phase)
          P_CLR: begin
            clr_n       = 1'b1;
            spawn_cnt_n = '0;
            phase_n     = P_REQ;
          end
          P_REQ: begin
            sreq_n  = 1'b1;
            phase_n = P_WAIT;
          end
          P_WAIT: begin
            if (spawn_done) begin
              if (spawn_cnt == SCW'(INIT_SPAWNS - 1)) begin
                state_n = S_IDLE;
              end else begin
                spawn_cnt_n = spawn_cnt + 1'b1;
                sreq_n      = 1'b1;
              end
            end else if (timer_hit) begin
              err_n   = 1'b1;
              state_n = S_IDLE;
            end else begin
              timer_n = timer + 1'b1;
            end
          end
          default: phase_n = P_CLR;
        endcase
      end
      S_IDLE: begin
        if (any_btn) begin
          state_n    = S_MOVE;
          start_n    = 1'b1;
          snapshot_n = board;
          if (btn_up)        dir_n = 2'b00;
          else if (btn_down) dir_n = 2'b01;
          else if (btn_left) dir_n = 2'b10;
          else               dir_n = 2'b11;
        end
      end
      S_MOVE: begin
        if (move_done) begin
          if (moved_board == snapshot) begin
            state_n = S_IDLE;
          end else begin
            if (move_count != 16'hFFFF) count_n = move_count + 16'd1;
            sreq_n  = 1'b1;
            state_n = S_SPAWN;
          end
        end else if (timer_hit) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_SPAWN: begin
        if (spawn_done) begin
          state_n = S_EVAL;
        end else if (timer_hit) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_EVAL: begin
        if (game_complete)  state_n = S_WIN;
        else if (game_over) state_n = S_LOSE;
        else                state_n = S_IDLE;
      end
      S_WIN, S_LOSE: begin
        if (any_btn) begin
          state_n = S_INIT;
          phase_n = P_CLR;
          count_n = '0;
          err_n   = 1'b0;
        end
      end
      default: begin
        state_n = S_INIT;
        phase_n = P_CLR;
      end
    endcase
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: stimulus queues expected output pulses,
// a monitor pops and compares them, and state checks cover each game phase.
module tb_move_sequencer;

  localparam int ST_INIT = 0, ST_IDLE = 1, ST_MOVE = 2, ST_SPAWN = 3;
  localparam int ST_WIN = 5, ST_LOSE = 6;
  localparam int EV_CLR = 1, EV_MOVE = 2, EV_SPAWN = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic [63:0] board, moved_board;
  logic        move_done, spawn_done, game_over, game_complete;
  logic        board_clr, move_start, spawn_req, busy, win, lose, err_timeout;
  logic [1:0]  move_dir;
  logic [15:0] move_count;
  logic [2:0]  state_o;

  int nChecks = 0;
  int nFails  = 0;
  int expKind[$];
  int expDir[$];
  bit spawnAuto = 1'b1;
  int spawnDelay = 3;
  bit moveAuto = 1'b1;
  int moveDelay = 1;

  move_sequencer #(.TIMEOUT_CYCLES(16), .INIT_SPAWNS(2)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .board(board), .moved_board(moved_board),
    .move_done(move_done), .spawn_done(spawn_done),
    .game_over(game_over), .game_complete(game_complete),
    .board_clr(board_clr), .move_start(move_start), .move_dir(move_dir),
    .spawn_req(spawn_req), .busy(busy), .win(win), .lose(lose),
    .err_timeout(err_timeout), .move_count(move_count), .state_o(state_o)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    nChecks++;
    if (actual !== required) begin
      nFails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic checkOutput(input string name, input int st, input bit bsy, input int cnt,
                             input bit err, input bit w, input bit l);
    check({name, ".state"}, 32'(state_o), 32'(st));
    check({name, ".busy"}, 32'(busy), 32'(bsy));
    check({name, ".count"}, 32'(move_count), 32'(cnt));
    check({name, ".err"}, 32'(err_timeout), 32'(err));
    check({name, ".win"}, 32'(win), 32'(w));
    check({name, ".lose"}, 32'(lose), 32'(l));
  endtask

  // Buttons are one-cycle pulses: set just after one edge, cleared after the next
  task automatic applyStimulus(input logic [3:0] btns);
    @(posedge clk); #1;
    {btn_up, btn_down, btn_left, btn_right} = btns;
    @(posedge clk); #1;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
  endtask

  task automatic pushEvent(input int kind, input int dir);
    expKind.push_back(kind);
    expDir.push_back(dir);
  endtask

  task automatic waitForState(input int st, input int maxCycles, input string name);
    int c = 0;
    while (32'(state_o) != st && c < maxCycles) begin
      @(negedge clk);
      c++;
    end
    nChecks++;
    if (32'(state_o) != st) begin
      nFails++;
      $display("[TB] FAIL %s: state_o=%0d required %0d within %0d cycles", name, state_o, st, maxCycles);
    end
  endtask

  task automatic countUntilIdle(output int cyc, output int moveCyc);
    cyc = 0;
    moveCyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (state_o == 3'(ST_MOVE)) moveCyc++;
    end while (state_o != 3'(ST_IDLE) && cyc < 100);
  endtask

  initial begin
    spawn_done = 1'b0;
    forever begin
      @(negedge clk);
      if (spawn_req && spawnAuto) begin
        repeat (spawnDelay) @(posedge clk);
        #1 spawn_done = 1'b1;
        @(posedge clk);
        #1 spawn_done = 1'b0;
      end
    end
  end

  initial begin
    move_done = 1'b0;
    forever begin
      @(negedge clk);
      if (move_start && moveAuto) begin
        repeat (moveDelay) @(posedge clk);
        #1 move_done = 1'b1;
        @(posedge clk);
        #1 move_done = 1'b0;
      end
    end
  end

  // Every output pulse must match the oldest expected event
  initial begin
    int kind, k, d;
    forever begin
      @(negedge clk);
      if (board_clr || move_start || spawn_req) begin
        kind = board_clr ? EV_CLR : (move_start ? EV_MOVE : EV_SPAWN);
        nChecks++;
        if (expKind.size() == 0) begin
          nFails++;
          $display("[TB] FAIL unexpectedEvent: actual kind=%0d required none", kind);
        end else begin
          k = expKind.pop_front();
          d = expDir.pop_front();
          if (kind != k || (k == EV_MOVE && 32'(move_dir) != d)) begin
            nFails++;
            $display("[TB] FAIL event: actual kind=%0d dir=%0d required kind=%0d dir=%0d",
                     kind, move_dir, k, d);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, moveCyc;
    rst = 1'b1;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    board = 64'h0000_0000_1100_0001;
    moved_board = 64'h0000_0000_0000_0002;
    game_over = 1'b0;
    game_complete = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset", ST_INIT, 1, 0, 0, 0, 0);
    check("reset.dir", 32'(move_dir), 0);
    check("reset.pulses", 32'({board_clr, move_start, spawn_req}), 0);
    pushEvent(EV_CLR, 0);
    pushEvent(EV_SPAWN, 0);
    pushEvent(EV_SPAWN, 0);
    @(posedge clk); #1 rst = 1'b0;
    waitForState(ST_IDLE, 60, "initToIdle");
    checkOutput("initDone", ST_IDLE, 0, 0, 0, 0, 0);
    check("initEvents", 32'(expKind.size()), 0);

    // up and left together: up wins, left dropped; effective move with 1-cycle responses
    spawnDelay = 1;
    pushEvent(EV_MOVE, 0);
    pushEvent(EV_SPAWN, 0);
    applyStimulus(4'b1010);
    countUntilIdle(cyc, moveCyc);
    check("turnaround", 32'(cyc), 6);
    checkOutput("effMove", ST_IDLE, 0, 1, 0, 0, 0);
    check("effEvents", 32'(expKind.size()), 0);

    moved_board = board;
    pushEvent(EV_MOVE, 1);
    applyStimulus(4'b0100);
    countUntilIdle(cyc, moveCyc);
    check("noopTurnaround", 32'(cyc), 3);
    checkOutput("noopMove", ST_IDLE, 0, 1, 0, 0, 0);
    check("noopDir", 32'(move_dir), 1);

    moved_board = 64'h0000_0000_0000_0012;
    game_complete = 1'b1;
    game_over = 1'b1;
    pushEvent(EV_MOVE, 3);
    pushEvent(EV_SPAWN, 0);
    applyStimulus(4'b0001);
    waitForState(ST_WIN, 20, "toWin");
    @(negedge clk);
    checkOutput("win", ST_WIN, 1, 2, 0, 1, 0);
    game_complete = 1'b0;
    game_over = 1'b0;

    spawnDelay = 3;
    pushEvent(EV_CLR, 0);
    pushEvent(EV_SPAWN, 0);
    pushEvent(EV_SPAWN, 0);
    applyStimulus(4'b0001);
    @(negedge clk);
    checkOutput("newGame", ST_INIT, 1, 0, 0, 0, 0);
    waitForState(ST_IDLE, 60, "newGameIdle");
    check("newGameEvents", 32'(expKind.size()), 0);

    spawnDelay = 1;
    game_over = 1'b1;
    pushEvent(EV_MOVE, 2);
    pushEvent(EV_SPAWN, 0);
    applyStimulus(4'b0010);
    waitForState(ST_LOSE, 20, "toLose");
    @(negedge clk);
    checkOutput("lose", ST_LOSE, 1, 1, 0, 0, 1);
    game_over = 1'b0;
    pushEvent(EV_CLR, 0);
    pushEvent(EV_SPAWN, 0);
    pushEvent(EV_SPAWN, 0);
    applyStimulus(4'b1000);
    waitForState(ST_IDLE, 60, "afterLose");
    checkOutput("afterLose", ST_IDLE, 0, 0, 0, 0, 0);

    // move_done on the very cycle the timer expires still counts as done
    moveDelay = 15;
    pushEvent(EV_MOVE, 0);
    pushEvent(EV_SPAWN, 0);
    applyStimulus(4'b1000);
    countUntilIdle(cyc, moveCyc);
    check("doneAtLimitCycles", 32'(moveCyc), 16);
    checkOutput("doneAtLimit", ST_IDLE, 0, 1, 0, 0, 0);

    moveAuto = 1'b0;
    pushEvent(EV_MOVE, 0);
    applyStimulus(4'b1000);
    countUntilIdle(cyc, moveCyc);
    check("timeoutCycles", 32'(moveCyc), 16);
    checkOutput("timeout", ST_IDLE, 0, 1, 1, 0, 0);

    moveAuto = 1'b1;
    moveDelay = 1;
    spawnAuto = 1'b0;
    pushEvent(EV_MOVE, 1);
    pushEvent(EV_SPAWN, 0);
    applyStimulus(4'b0100);
    waitForState(ST_SPAWN, 10, "toSpawn");
    applyStimulus(4'b0010);
    @(negedge clk);
    checkOutput("spawnHeld", ST_SPAWN, 1, 2, 1, 0, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midSpawnReset", ST_INIT, 1, 0, 0, 0, 0);
    spawnAuto = 1'b1;
    spawnDelay = 3;
    pushEvent(EV_CLR, 0);
    pushEvent(EV_SPAWN, 0);
    pushEvent(EV_SPAWN, 0);
    @(posedge clk); #1 rst = 1'b0;
    waitForState(ST_IDLE, 60, "resetIdle");
    repeat (3) @(negedge clk);
    checkOutput("final", ST_IDLE, 0, 0, 0, 0, 0);
    check("finalEvents", 32'(expKind.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
